// File: rtl/ps2_keyboard_decoder.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder
//
// Receives the raw PS/2 keyboard clock/data pair, removes glitches from the
// clock, deframes 11-bit frames (start, 8 data LSB first, odd parity, stop)
// and folds the E0 (extended) and F0 (break) prefixes into one key event.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous to clk)
//   ps2_data   raw PS/2 data  (asynchronous to clk)
//   keycode    last completed scancode, prefixes stripped (held)
//   key_make   1 = press, 0 = release for keycode (held)
//   key_ext    1 = keycode was preceded by E0 (held)
//   key_valid  one-cycle pulse when keycode/key_make/key_ext update
//   frame_err  one-cycle pulse on start/parity/stop error or timeout
// ---------------------------------------------------------------------------
module ps2_keyboard_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchronizers and clock filter. Everything idles high like the bus.
    logic          clk_s1, clk_s2;
    logic          data_s1, data_s2;
    logic          clk_filt, clk_filt_q;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            data_s1    <= ps2_data;
            data_s2    <= data_s1;
            clk_filt_q <= clk_filt;
            // The filtered level only follows after FILTER_LEN consecutive
            // samples that disagree with it; any agreeing sample restarts.
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Single-cycle event on a filtered 1->0 transition.
    assign fall = clk_filt_q & ~clk_filt;

    // Deframing FSM, prefix folding and registered outputs.
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic          pend_ext, pend_brk;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            parity    <= 1'b0;
            pend_ext  <= 1'b0;
            pend_brk  <= 1'b0;
            to_cnt    <= '0;
            keycode   <= '0;
            key_make  <= 1'b0;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;

            if (fall || state == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            // A stalled frame is abandoned; this takes priority over a fall
            // arriving in the same cycle.
            if (timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                pend_ext  <= 1'b0;
                pend_brk  <= 1'b0;
                to_cnt    <= '0;
            end else if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity <= data_s2;
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_s2 && ((^shift ^ parity) == 1'b1)) begin
                            case (shift)
                                8'hE0: pend_ext <= 1'b1;
                                8'hF0: pend_brk <= 1'b1;
                                default: begin
                                    keycode   <= shift;
                                    key_make  <= ~pend_brk;
                                    key_ext   <= pend_ext;
                                    key_valid <= 1'b1;
                                    pend_ext  <= 1'b0;
                                    pend_brk  <= 1'b0;
                                end
                            endcase
                        end else begin
                            frame_err <= 1'b1;
                            pend_ext  <= 1'b0;
                            pend_brk  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
module tb_ps2_keyboard_decoder;

    localparam int TO = 1000;
    localparam int HALF = 20;   // clk cycles per PS/2 clock phase

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_make, key_ext, key_valid, frame_err;

    int checks = 0;
    int errors = 0;
    int vcnt = 0, ecnt = 0, both_cnt = 0;
    int v0, e0;

    ps2_keyboard_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .key_make(key_make), .key_ext(key_ext),
        .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (key_valid) vcnt++;
        if (frame_err) ecnt++;
        if (key_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data changes while the clock is high, then low/high phases.
    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame; parity may be flipped, stop forced.
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
    endtask

    task automatic mark();
        v0 = vcnt;
        e0 = ecnt;
    endtask

    initial begin
        // Reset state
        wait_clks(5);
        check("rst_keycode", keycode, 8'h00);
        check("rst_make", key_make, 0);
        check("rst_ext", key_ext, 0);
        check("rst_valid", key_valid, 0);
        check("rst_err", frame_err, 0);
        reset = 1'b1;
        wait_clks(5);

        // Make 0x1D
        mark();
        good(8'h1D);
        check("make_valid_cnt", vcnt - v0, 1);
        check("make_err_cnt", ecnt - e0, 0);
        check("make_keycode", keycode, 8'h1D);
        check("make_make", key_make, 1);
        check("make_ext", key_ext, 0);

        // Extended break E0 F0 75
        mark();
        good(8'hE0);
        good(8'hF0);
        check("prefix_no_valid", vcnt - v0, 0);
        check("prefix_keycode_held", keycode, 8'h1D);
        good(8'h75);
        check("brk_valid_cnt", vcnt - v0, 1);
        check("brk_keycode", keycode, 8'h75);
        check("brk_make", key_make, 0);
        check("brk_ext", key_ext, 1);

        // Flags cleared after the event
        good(8'h1C);
        check("after_keycode", keycode, 8'h1C);
        check("after_make", key_make, 1);
        check("after_ext", key_ext, 0);

        // Parity error
        mark();
        send_frame(8'h1D, 1'b1, 1'b1, 11);
        check("par_err_cnt", ecnt - e0, 1);
        check("par_no_valid", vcnt - v0, 0);
        check("par_keycode_held", keycode, 8'h1C);
        good(8'h1B);
        check("par_next_keycode", keycode, 8'h1B);

        // Prefix flushed by a bad stop bit
        mark();
        good(8'hE0);
        send_frame(8'h33, 1'b0, 1'b0, 11);
        check("stop_err_cnt", ecnt - e0, 1);
        good(8'h6B);
        check("flush_keycode", keycode, 8'h6B);
        check("flush_ext", key_ext, 0);
        check("flush_valid_cnt", vcnt - v0, 1);

        // Timeout after 4 data bits
        mark();
        send_frame(8'h29, 1'b0, 1'b1, 5);
        wait_clks(TO + 200);
        check("to_err_cnt", ecnt - e0, 1);
        check("to_no_valid", vcnt - v0, 0);
        good(8'h29);
        check("to_next_keycode", keycode, 8'h29);
        check("to_next_valid_cnt", vcnt - v0, 1);

        // Release repeated-prefix: F0 F0 E0 5A
        good(8'hF0);
        good(8'hF0);
        good(8'hE0);
        good(8'h5A);
        check("rep_keycode", keycode, 8'h5A);
        check("rep_make", key_make, 0);
        check("rep_ext", key_ext, 1);

        // Short glitch mid-frame must not shift an extra bit
        mark();
        begin
            logic [10:0] f;
            f = {1'b1, ~^8'h4D, 8'h4D, 1'b0};
            for (int i = 0; i < 4; i++) send_bit(f[i]);
            ps2_clk = 1'b0;
            wait_clks(2);
            ps2_clk = 1'b1;
            wait_clks(HALF);
            for (int i = 4; i < 11; i++) send_bit(f[i]);
            ps2_data = 1'b1;
            wait_clks(HALF);
        end
        check("glitch_keycode", keycode, 8'h4D);
        check("glitch_err_cnt", ecnt - e0, 0);
        check("glitch_valid_cnt", vcnt - v0, 1);

        // Reset mid-frame
        send_frame(8'h12, 1'b0, 1'b1, 3);
        reset = 1'b0;
        wait_clks(3);
        check("midrst_keycode", keycode, 8'h00);
        check("midrst_make", key_make, 0);
        check("midrst_ext", key_ext, 0);
        reset = 1'b1;
        wait_clks(HALF);
        mark();
        good(8'h1D);
        check("post_rst_keycode", keycode, 8'h1D);
        check("post_rst_make", key_make, 1);
        check("post_rst_valid_cnt", vcnt - v0, 1);
        check("post_rst_err_cnt", ecnt - e0, 0);

        check("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
